// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between instruction fetch (port 0) and load/store (port 1).
// Latency : grant in cycle 0, mem_req from cycle 1, pX_rvalid one cycle after mem_rvalid (min 3).
// Backpr. : one transaction in flight; requesters hold req until gnt, memory holds off via mem_ack.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   pX_req/we/addr/wdata          requester X transaction, held stable until pX_gnt
//   pX_gnt                        combinational accept, only ever asserted in IDLE
//   pX_rvalid/pX_err              one-cycle response pulse to the owner, err = timed out
//   rdata                         shared response data, valid with pX_rvalid
//   mem_req/we/addr/wdata         request to memory, held until mem_ack
//   mem_ack/mem_rvalid/mem_rdata  memory accept, memory response and read data
module mem_port_arbiter #(
    parameter int word_width = 32,
    parameter int PRIO_MODE  = 0,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [word_width-1:0] p0_addr,
    input  logic [word_width-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [word_width-1:0] p1_addr,
    input  logic [word_width-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic                  p1_err,
    output logic [word_width-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [word_width-1:0] mem_addr,
    output logic [word_width-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [word_width-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state;
    logic             owner;       // 0 = port 0, 1 = port 1
    logic             last_owner;  // owner of the most recently completed transaction
    logic [CNT_W-1:0] cnt;

    logic tie_to_p0;
    logic win0;
    logic win1;
    logic grant_ok;
    logic timed_out;
    logic done;
    logic done_err;
    logic capture;

    // On a tie, round-robin favours the port that did not go last; fixed mode favours port 1.
    assign tie_to_p0 = (PRIO_MODE == 0) ? last_owner : 1'b0;
    assign win0      = p0_req & (~p1_req | tie_to_p0);
    assign win1      = p1_req & ~win0;

    // Qualified with rst so the grants read 0 while reset is held, like every other output.
    assign grant_ok  = (state == IDLE) & rst;
    assign p0_gnt    = grant_ok & win0;
    assign p1_gnt    = grant_ok & win1;

    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    // A real completion in the same cycle as the last allowed count wins over the timeout.
    always_comb begin
        done     = 1'b0;
        done_err = 1'b0;
        capture  = 1'b0;
        case (state)
            REQ: begin
                capture  = mem_ack & mem_rvalid;
                done     = capture | timed_out;
                done_err = ~capture & timed_out;
            end
            WAIT: begin
                capture  = mem_rvalid;
                done     = capture | timed_out;
                done_err = ~capture & timed_out;
            end
            default: begin
                capture  = 1'b0;
                done     = 1'b0;
                done_err = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            p0_rvalid  <= 1'b0;
            p0_err     <= 1'b0;
            p1_rvalid  <= 1'b0;
            p1_err     <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // Response flags are single-cycle pulses unless set again below.
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;

            if (capture) begin
                rdata <= mem_rdata;
            end

            case (state)
                IDLE: begin
                    if (p0_gnt || p1_gnt) begin
                        owner     <= p1_gnt;
                        mem_we    <= p1_gnt ? p1_we    : p0_we;
                        mem_addr  <= p1_gnt ? p1_addr  : p0_addr;
                        mem_wdata <= p1_gnt ? p1_wdata : p0_wdata;
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (done) begin
                        mem_req   <= 1'b0;
                        p0_rvalid <= ~owner;
                        p1_rvalid <= owner;
                        p0_err    <= ~owner & done_err;
                        p1_err    <= owner & done_err;
                        state     <= RESP;
                    end else if (state == REQ && mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                RESP: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
